// File: rtl/fmul_sched_pkg.sv
// Shared types and constants for the float_mult round-robin scheduler.
// Optional watchdog: define FMUL_SCHED_TIMEOUT_EN.
package fmul_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic FMT_FP16 = 1'b0;
  localparam logic FMT_FP32 = 1'b1;

  localparam logic [31:0] NAN_32 = 32'h7FFF_FFFF;
  localparam logic [15:0] NAN_16 = 16'h7FFF;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmul_rr_scheduler_rr_grant.sv
// Rotate-priority one-hot grant: first requester at or after ptr wins.
// Pure combinational; the caller owns the pointer register.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fmul_rr_scheduler.sv
// Shares one float_mult among NUM_REQ requesters, one op in flight.
// Define FMUL_SCHED_TIMEOUT_EN to add a WAIT-state watchdog.
module fmul_rr_scheduler
  import fmul_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_type,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  output logic [2:0]             resp_id,
  output logic [31:0]            resp_data,
  output logic                   resp_ovf,
  output logic                   resp_err,
  output logic                   mul_valid,
  output logic                   mul_type,
  output logic [31:0]            mul_in1_32,
  output logic [31:0]            mul_in2_32,
  output logic [15:0]            mul_in1_16,
  output logic [15:0]            mul_in2_16,
  input  logic                   mul_ready,
  input  logic [31:0]            mul_out_32,
  input  logic [15:0]            mul_out_16,
  input  logic                   mul_ovf,
  input  logic                   mul_err
);

  localparam int IW = id_w(NUM_REQ);

  state_t state_q, state_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    id_q;
  logic             type_q;
  logic [31:0]      a_q, b_q;
  logic [7:0]       set_cnt_q;
  logic [2:0]       rid_q;
  logic [31:0]      rdata_q;
  logic             rovf_q, rerr_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_id;
  logic               any_gnt;
  logic               accept;
  logic               cap;
  logic               sel_type;
  logic [31:0]        sel_a, sel_b;
  logic               busy;

  rr_grant #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_grant (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any_gnt)
  );

  assign accept = (state_q == S_IDLE) && !rst
                && mul_ready && any_gnt;

  assign req_ready = accept ? gnt : '0;

  always_comb begin
    sel_type = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_type = req_type[i];
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
      end
    end
  end

`ifdef FMUL_SCHED_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        tmo_fire;

  assign tmo_fire = (state_q == S_WAIT) && !mul_ready
                  && (tmo_q >= 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (accept) begin
      tmo_q <= '0;
    end else if (state_q != S_IDLE) begin
      tmo_q <= tmo_q + 16'd1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: begin
        if (set_cnt_q == 8'(SETTLE_CYC - 1))
          state_d = S_WAIT;
      end
      S_WAIT: begin
`ifdef FMUL_SCHED_TIMEOUT_EN
        if (mul_ready || tmo_fire) state_d = S_RESP;
`else
        if (mul_ready) state_d = S_RESP;
`endif
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign cap = (state_q == S_WAIT) && (state_d == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      type_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      set_cnt_q <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rovf_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= gnt_id;
        type_q <= sel_type;
        a_q    <= sel_a;
        b_q    <= sel_b;
        ptr_q  <= (gnt_id == IW'(NUM_REQ - 1)) ? '0
                : gnt_id + IW'(1);
      end
      if (state_q == S_SETTLE)
        set_cnt_q <= set_cnt_q + 8'd1;
      else
        set_cnt_q <= '0;
      if (cap) begin
        rid_q <= 3'(id_q);
`ifdef FMUL_SCHED_TIMEOUT_EN
        if (tmo_fire) begin
          rdata_q <= (type_q == FMT_FP32) ? NAN_32
                   : {16'h0, NAN_16};
          rovf_q  <= 1'b0;
          rerr_q  <= 1'b1;
        end else begin
          rdata_q <= (type_q == FMT_FP32) ? mul_out_32
                   : {16'h0, mul_out_16};
          rovf_q  <= mul_ovf;
          rerr_q  <= mul_err;
        end
`else
        rdata_q <= (type_q == FMT_FP32) ? mul_out_32
                 : {16'h0, mul_out_16};
        rovf_q  <= mul_ovf;
        rerr_q  <= mul_err;
`endif
      end
    end
  end

  // operands only reach the multiplier while an op is in flight
  assign busy = (state_q != S_IDLE);

  assign mul_valid  = (state_q == S_ISSUE);
  assign mul_type   = busy & type_q;
  assign mul_in1_32 = (busy && type_q == FMT_FP32) ? a_q : '0;
  assign mul_in2_32 = (busy && type_q == FMT_FP32) ? b_q : '0;
  assign mul_in1_16 = (busy && type_q == FMT_FP16) ? a_q[15:0] : '0;
  assign mul_in2_16 = (busy && type_q == FMT_FP16) ? b_q[15:0] : '0;

  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = rid_q;
  assign resp_data  = rdata_q;
  assign resp_ovf   = rovf_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// Directed bench for fmul_rr_scheduler with a small float_mult ready model.
// Watchdog scenario runs only when FMUL_SCHED_TIMEOUT_EN is defined.
module tb_fmul_rr_scheduler;

  localparam int N  = 4;
  localparam int SC = 3;
  localparam int TC = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_type;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [2:0]      resp_id;
  logic [31:0]     resp_data;
  logic            resp_ovf;
  logic            resp_err;
  logic            mul_valid;
  logic            mul_type;
  logic [31:0]     mul_in1_32, mul_in2_32;
  logic [15:0]     mul_in1_16, mul_in2_16;
  logic            mul_ready;
  logic [31:0]     mul_out_32;
  logic [15:0]     mul_out_16;
  logic            mul_ovf;
  logic            mul_err;

  int pass_cnt = 0;
  int total    = 0;

  logic short_op;
  logic force_low;
  int   busy;

  int g_ord[8];
  int r_ord[8];
  int ng, nr;

  always #5 clk = ~clk;

  fmul_rr_scheduler #(
    .NUM_REQ     (N),
    .SETTLE_CYC  (SC),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ovf   (resp_ovf),
    .resp_err   (resp_err),
    .mul_valid  (mul_valid),
    .mul_type   (mul_type),
    .mul_in1_32 (mul_in1_32),
    .mul_in2_32 (mul_in2_32),
    .mul_in1_16 (mul_in1_16),
    .mul_in2_16 (mul_in2_16),
    .mul_ready  (mul_ready),
    .mul_out_32 (mul_out_32),
    .mul_out_16 (mul_out_16),
    .mul_ovf    (mul_ovf),
    .mul_err    (mul_err)
  );

  // ready drops for 5 cycles after valid unless the shortcut applies
  always @(posedge clk) begin
    if (rst) busy <= 0;
    else if (mul_valid && !short_op) busy <= 5;
    else if (busy > 0) busy <= busy - 1;
  end

  assign mul_ready = (busy == 0) && !force_low;

  task automatic one_op(
    input  int          id,
    input  logic        typ,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] o32,
    input  logic [15:0] o16,
    input  logic        ovf,
    input  logic        err,
    input  logic        shortc,
    output int          lat,
    output logic [2:0]  rid,
    output logic [31:0] rdata,
    output logic        rovf,
    output logic        rerr,
    output logic        in32_seen,
    output logic [31:0] v_in1_32,
    output logic [15:0] v_in1_16,
    output logic        got
  );
    logic granted;
    mul_out_32 = o32;
    mul_out_16 = o16;
    mul_ovf    = ovf;
    mul_err    = err;
    short_op   = shortc;
    req_type[id]       = typ;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid[id]      = 1'b1;
    got = 1'b0; granted = 1'b0; in32_seen = 1'b0;
    lat = 0; rid = '0; rdata = '0; rovf = 1'b0; rerr = 1'b0;
    v_in1_32 = '0; v_in1_16 = '0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready[id]) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    if (granted) begin
      for (int n = 1; n <= 200; n++) begin
        @(negedge clk);
        #1;
        if ((mul_in1_32 | mul_in2_32) != 0) in32_seen = 1'b1;
        if (mul_valid) begin
          v_in1_32 = mul_in1_32;
          v_in1_16 = mul_in1_16;
        end
        if (resp_valid) begin
          got = 1'b1; lat = n;
          rid = resp_id; rdata = resp_data;
          rovf = resp_ovf; rerr = resp_err;
          break;
        end
      end
    end
  endtask

  task automatic run_multi(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int want;
    want = $countones(mask);
    ng = 0; nr = 0;
    req_type  = '1;
    short_op  = 1'b1;
    req_valid = mask;
    for (int c = 0; c < 300 && nr < want; c++) begin
      #1;
      pend = req_ready;
      for (int i = 0; i < N; i++)
        if (pend[i] && ng < 8) begin
          g_ord[ng] = i; ng++;
        end
      if (resp_valid && nr < 8) begin
        r_ord[nr] = int'(resp_id); nr++;
      end
      @(posedge clk);
      #1 req_valid = req_valid & ~pend;
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  int          lat;
  logic [2:0]  rid;
  logic [31:0] rdata;
  logic        rovf, rerr, in32, got;
  logic [31:0] v32;
  logic [15:0] v16;

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ({req_ready, resp_valid, mul_valid, mul_type, resp_id,
         resp_ovf, resp_err} !== '0)
      $display("FAIL reset_ctrl got rdy=%b rv=%b mv=%b id=%0d want all 0",
               req_ready, resp_valid, mul_valid, resp_id);
    else pass_cnt++;
    total++;
    if ({resp_data, mul_in1_32, mul_in2_32, mul_in1_16, mul_in2_16} !== '0)
      $display("FAIL reset_data got data=%h in1=%h want 0",
               resp_data, mul_in1_32);
    else pass_cnt++;
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fp32();
    one_op(0, 1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000,
           16'hBEEF, 1'b0, 1'b0, 1'b0,
           lat, rid, rdata, rovf, rerr, in32, v32, v16, got);
    total++;
    if (!got || rid !== 3'd0 || rdata !== 32'h40C0_0000)
      $display("FAIL fp32_result got got=%b id=%0d data=%h want id=0 data=40c00000",
               got, rid, rdata);
    else pass_cnt++;
    total++;
    if ({rovf, rerr} !== 2'b00)
      $display("FAIL fp32_flags got %b%b want 00", rovf, rerr);
    else pass_cnt++;
    total++;
    if (lat !== SC + 5)
      $display("FAIL fp32_latency got %0d want %0d", lat, SC + 5);
    else pass_cnt++;
    total++;
    if (v32 !== 32'h4000_0000 || v16 !== 16'h0)
      $display("FAIL fp32_operand got in32=%h in16=%h want 40000000/0000",
               v32, v16);
    else pass_cnt++;
    @(negedge clk); #1;
    total++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h40C0_0000)
      $display("FAIL resp_hold got rv=%b data=%h want 0/40c00000",
               resp_valid, resp_data);
    else pass_cnt++;
  endtask

  task automatic test_fp16();
    one_op(2, 1'b0, 32'h0000_3E00, 32'h0000_4000, 32'hDEAD_BEEF,
           16'h4200, 1'b0, 1'b0, 1'b0,
           lat, rid, rdata, rovf, rerr, in32, v32, v16, got);
    total++;
    if (!got || rid !== 3'd2 || rdata !== 32'h0000_4200)
      $display("FAIL fp16_result got got=%b id=%0d data=%h want id=2 data=00004200",
               got, rid, rdata);
    else pass_cnt++;
    total++;
    if (in32 !== 1'b0 || v16 !== 16'h3E00)
      $display("FAIL fp16_operand got in32_nz=%b in16=%h want 0/3e00",
               in32, v16);
    else pass_cnt++;
  endtask

  task automatic test_all_same_cycle();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    run_multi(4'b1111);
    total++;
    if (ng != 4 || g_ord[0] != 0 || g_ord[1] != 1
        || g_ord[2] != 2 || g_ord[3] != 3)
      $display("FAIL all4_grant got n=%0d %0d%0d%0d%0d want 4 0123",
               ng, g_ord[0], g_ord[1], g_ord[2], g_ord[3]);
    else pass_cnt++;
    total++;
    if (nr != 4 || r_ord[0] != 0 || r_ord[1] != 1
        || r_ord[2] != 2 || r_ord[3] != 3)
      $display("FAIL all4_resp got n=%0d %0d%0d%0d%0d want 4 0123",
               nr, r_ord[0], r_ord[1], r_ord[2], r_ord[3]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_multi(4'b0110);
    total++;
    if (ng != 2 || g_ord[0] != 1 || g_ord[1] != 2)
      $display("FAIL rr_round2 got n=%0d %0d%0d want 2 12",
               ng, g_ord[0], g_ord[1]);
    else pass_cnt++;
    run_multi(4'b0011);
    total++;
    if (ng != 2 || g_ord[0] != 0 || g_ord[1] != 1)
      $display("FAIL rr_wrap got n=%0d %0d%0d want 2 01",
               ng, g_ord[0], g_ord[1]);
    else pass_cnt++;
  endtask

  task automatic test_zero_shortcut();
    one_op(1, 1'b1, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000,
           16'h0, 1'b0, 1'b0, 1'b1,
           lat, rid, rdata, rovf, rerr, in32, v32, v16, got);
    total++;
    if (!got || rid !== 3'd1 || rdata !== 32'h0)
      $display("FAIL zero_result got got=%b id=%0d data=%h want id=1 data=0",
               got, rid, rdata);
    else pass_cnt++;
    total++;
    if (lat !== SC + 3)
      $display("FAIL zero_latency got %0d want %0d", lat, SC + 3);
    else pass_cnt++;
  endtask

  task automatic test_nan();
    one_op(3, 1'b1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FFF_FFFF,
           16'h0, 1'b0, 1'b1, 1'b1,
           lat, rid, rdata, rovf, rerr, in32, v32, v16, got);
    total++;
    if (!got || rid !== 3'd3 || rdata !== 32'h7FFF_FFFF || rerr !== 1'b1)
      $display("FAIL nan_result got id=%0d data=%h err=%b want 3/7fffffff/1",
               rid, rdata, rerr);
    else pass_cnt++;
  endtask

  task automatic test_ovf();
    one_op(0, 1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000,
           16'h0, 1'b1, 1'b0, 1'b0,
           lat, rid, rdata, rovf, rerr, in32, v32, v16, got);
    total++;
    if (!got || rdata !== 32'h7F80_0000 || rovf !== 1'b1 || rerr !== 1'b0)
      $display("FAIL ovf_result got data=%h ovf=%b err=%b want 7f800000/1/0",
               rdata, rovf, rerr);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    logic granted;
    granted = 1'b0;
    short_op = 1'b0;
    req_type[0] = 1'b1;
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h3F80_0000;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready[0]) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    force_low = 1'b1;
    repeat (SC + 3) @(negedge clk);
    #1;
    total++;
    if (!granted || mul_in1_32 !== 32'h3F80_0000)
      $display("FAIL wait_inflight got granted=%b in1=%h want 1/3f800000",
               granted, mul_in1_32);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    force_low = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({resp_valid, mul_valid, mul_type, resp_id, resp_ovf, resp_err} !== '0
        || {resp_data, mul_in1_32, mul_in2_32} !== '0)
      $display("FAIL wait_reset got rv=%b mv=%b data=%h in1=%h want all 0",
               resp_valid, mul_valid, resp_data, mul_in1_32);
    else pass_cnt++;
    one_op(2, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000,
           16'h0, 1'b0, 1'b0, 1'b1,
           lat, rid, rdata, rovf, rerr, in32, v32, v16, got);
    total++;
    if (!got || rid !== 3'd2 || lat !== SC + 3 || rdata !== 32'h4000_0000)
      $display("FAIL post_reset_op got got=%b id=%0d lat=%0d data=%h want 1/2/%0d/40000000",
               got, rid, lat, rdata, SC + 3);
    else pass_cnt++;
  endtask

`ifdef FMUL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    short_op = 1'b0;
    req_type[1] = 1'b1;
    req_a[63:32] = 32'h3F80_0000;
    req_b[63:32] = 32'h3F80_0000;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (req_ready[1]) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    force_low = 1'b1;
    for (int n = 0; n < TC + 40; n++) begin
      @(negedge clk); #1;
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || resp_err !== 1'b1 || resp_ovf !== 1'b0
        || resp_data !== 32'h7FFF_FFFF)
      $display("FAIL timeout got seen=%b err=%b ovf=%b data=%h want 1/1/0/7fffffff",
               seen, resp_err, resp_ovf, resp_data);
    else pass_cnt++;
    force_low = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_type   = '0;
    req_a      = '0;
    req_b      = '0;
    mul_out_32 = '0;
    mul_out_16 = '0;
    mul_ovf    = 1'b0;
    mul_err    = 1'b0;
    short_op   = 1'b0;
    force_low  = 1'b0;
    @(negedge clk);
    test_reset();
    test_fp32();
    test_fp16();
    test_all_same_cycle();
    test_back_to_back();
    test_zero_shortcut();
    test_nan();
    test_ovf();
    test_reset_in_wait();
`ifdef FMUL_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
